// File: rtl/mmio_io_port_if.sv
// rtl/mmio_io_port_if.sv - data-memory bus and stream handshake signals of the MMIO I/O port
interface mmio_io_port_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic        MemWrite;
  logic        MemRead;
  logic        Hit;
  logic [31:0] ReadData;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport slave (
    input  Addr, WriteData, ByteEn, MemWrite, MemRead, out_ready, in_data, in_valid,
    output Hit, ReadData, out_data, out_valid, in_ready
  );

  modport master (
    output Addr, WriteData, ByteEn, MemWrite, MemRead, out_ready, in_data, in_valid,
    input  Hit, ReadData, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/mmio_io_port.sv
// rtl/mmio_io_port.sv - MMIO port with output/input FIFOs and a STATUS register on the data-memory bus
module mmio_io_port #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] OUT0_ADDR = 16'd256,
  parameter logic [15:0] STAT_ADDR = 16'd260,
  parameter logic [15:0] IN0_ADDR  = 16'd272
) (
  input  logic           clk,
  input  logic           rst,
  mmio_io_port_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   out_mem_q [DEPTH];
  logic [31:0]   out_mem_d [DEPTH];
  logic [31:0]   in_mem_q  [DEPTH];
  logic [31:0]   in_mem_d  [DEPTH];
  logic [PW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [PW-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  logic        hit_out, hit_stat, hit_in;
  logic        out_empty, out_full, in_empty, in_full;
  logic        out_pop, out_push_req, out_push, ovf_set, ovf_clr;
  logic        in_push, in_pop, unf_set, unf_clr;
  logic [31:0] lane_mask, status_word;
  logic        unused_addr;

  assign unused_addr = ^{bus.Addr[31:16], bus.Addr[1:0]};

  assign hit_out  = (bus.Addr[15:2] == OUT0_ADDR[15:2]);
  assign hit_stat = (bus.Addr[15:2] == STAT_ADDR[15:2]);
  assign hit_in   = (bus.Addr[15:2] == IN0_ADDR[15:2]);

  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign in_empty  = (in_cnt_q == '0);
  assign in_full   = (in_cnt_q == FULL_CNT);

  assign lane_mask = {{8{bus.ByteEn[3]}}, {8{bus.ByteEn[2]}}, {8{bus.ByteEn[1]}}, {8{bus.ByteEn[0]}}};

  // A push into a full output FIFO is still legal when the consumer pops in the same cycle.
  assign out_pop      = !out_empty && bus.out_ready;
  assign out_push_req = bus.MemWrite && hit_out;
  assign out_push     = out_push_req && (!out_full || out_pop);
  assign ovf_set      = out_push_req && out_full && !out_pop;
  assign ovf_clr      = bus.MemWrite && hit_stat && bus.ByteEn[0] && bus.WriteData[4];

  assign in_push = bus.in_valid && !in_full;
  assign in_pop  = bus.MemRead && hit_in && !in_empty;
  assign unf_set = bus.MemRead && hit_in && in_empty;
  assign unf_clr = bus.MemWrite && hit_stat && bus.ByteEn[0] && bus.WriteData[5];

  assign status_word = {8'h00, 8'(out_cnt_q), 8'(in_cnt_q),
                        2'b00, unf_q, ovf_q, out_full, out_empty, in_full, !in_empty};

  assign bus.Hit       = hit_out || hit_stat || hit_in;
  assign bus.out_valid = !out_empty;
  assign bus.out_data  = out_empty ? 32'h0 : out_mem_q[out_rd_q];
  assign bus.in_ready  = !in_full;

  always_comb begin
    bus.ReadData = 32'h0;
    if (hit_stat)
      bus.ReadData = status_word;
    else if (hit_in && !in_empty)
      bus.ReadData = in_mem_q[in_rd_q];
  end

  always_comb begin
    out_mem_d = out_mem_q;
    in_mem_d  = in_mem_q;
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    out_cnt_d = out_cnt_q;
    in_rd_d   = in_rd_q;
    in_wr_d   = in_wr_q;
    in_cnt_d  = in_cnt_q;

    if (out_push) begin
      out_mem_d[out_wr_q] = bus.WriteData & lane_mask;
      out_wr_d            = out_wr_q + PW'(1);
    end
    if (out_pop)
      out_rd_d = out_rd_q + PW'(1);
    if (out_push && !out_pop)
      out_cnt_d = out_cnt_q + CW'(1);
    else if (!out_push && out_pop)
      out_cnt_d = out_cnt_q - CW'(1);

    if (in_push) begin
      in_mem_d[in_wr_q] = bus.in_data;
      in_wr_d           = in_wr_q + PW'(1);
    end
    if (in_pop)
      in_rd_d = in_rd_q + PW'(1);
    if (in_push && !in_pop)
      in_cnt_d = in_cnt_q + CW'(1);
    else if (!in_push && in_pop)
      in_cnt_d = in_cnt_q - CW'(1);

    // Setting wins over a same-cycle write-one-to-clear.
    ovf_d = ovf_set || (ovf_q && !ovf_clr);
    unf_d = unf_set || (unf_q && !unf_clr);
  end

  always_ff @(posedge clk) begin
    out_mem_q <= out_mem_d;
    in_mem_q  <= in_mem_d;
    if (rst) begin
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      in_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_cnt_q  <= in_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
endmodule

// File: tb/tb_mmio_io_port.sv
// tb/tb_mmio_io_port.sv - directed self-checking bench for mmio_io_port
module tb_mmio_io_port;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  mmio_io_port_if bus_if ();

  mmio_io_port #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus_if.Addr = a; bus_if.WriteData = d; bus_if.ByteEn = be; bus_if.MemWrite = 1'b1;
    @(posedge clk);
    #1 bus_if.MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.Addr = a; bus_if.MemRead = 1'b1;
    #1 d = bus_if.ReadData;
    @(posedge clk);
    #1 bus_if.MemRead = 1'b0;
  endtask

  task automatic pop_out();
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.out_ready = 1'b0;
  endtask

  task automatic push_in(input logic [31:0] d);
    @(negedge clk);
    bus_if.in_valid = 1'b1; bus_if.in_data = d;
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if (bus_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus_if.out_valid); end
    vectors++;
    if (bus_if.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", bus_if.in_ready); end
    vectors++;
    if (bus_if.out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus_if.out_data); end
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL reset_status got %h want 00000004", rd); end
  endtask

  task automatic test_store_word();
    do_store(32'd256, 32'hDEAD_BEEF, 4'b1111);
    vectors++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL sw_appear got v=%0b d=%h want v=1 d=deadbeef", bus_if.out_valid, bus_if.out_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 32'hDEAD_BEEF) begin
        miscompares++; $display("FAIL sw_hold got v=%0b d=%h want v=1 d=deadbeef", bus_if.out_valid, bus_if.out_data);
      end
    end
    pop_out();
    vectors++;
    if (bus_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL sw_drain got v=%0b want 0", bus_if.out_valid); end
  endtask

  task automatic test_store_byte();
    do_store(32'h1234_0103, 32'hFFFF_FFAF, 4'b0001);
    vectors++;
    if (bus_if.out_data !== 32'h0000_00AF) begin miscompares++; $display("FAIL sb_mask got %h want 000000af", bus_if.out_data); end
    pop_out();
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    for (int i = 1; i <= 5; i++) do_store(32'd256, i, 4'b1111);
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0004_0018) begin miscompares++; $display("FAIL ovf_status got %h want 00040018", rd); end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (bus_if.out_data !== 32'(i)) begin miscompares++; $display("FAIL ovf_drain got %h want %h", bus_if.out_data, i); end
      pop_out();
    end
    vectors++;
    if (bus_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %0b want 0", bus_if.out_valid); end
    do_store(32'd260, 32'h10, 4'b0001);
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL ovf_clear got %h want 00000004", rd); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) do_store(32'd256, 32'h10 + i, 4'b1111);
    @(negedge clk);
    bus_if.Addr = 32'd256; bus_if.WriteData = 32'h14; bus_if.ByteEn = 4'b1111;
    bus_if.MemWrite = 1'b1; bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.MemWrite = 1'b0; bus_if.out_ready = 1'b0;
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0004_0008) begin miscompares++; $display("FAIL fullpp_status got %h want 00040008", rd); end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (bus_if.out_data !== 32'h10 + i) begin miscompares++; $display("FAIL fullpp_drain got %h want %h", bus_if.out_data, 32'h10 + i); end
      pop_out();
    end
  endtask

  task automatic test_input();
    logic [31:0] rd;
    push_in(32'h11);
    push_in(32'h22);
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0205) begin miscompares++; $display("FAIL in_status got %h want 00000205", rd); end
    do_load(32'd272, rd);
    vectors++;
    if (rd !== 32'h11) begin miscompares++; $display("FAIL in_lw1 got %h want 11", rd); end
    do_load(32'd272, rd);
    vectors++;
    if (rd !== 32'h22) begin miscompares++; $display("FAIL in_lw2 got %h want 22", rd); end
    do_load(32'd272, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL in_lw_empty got %h want 0", rd); end
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0024) begin miscompares++; $display("FAIL in_unf got %h want 00000024", rd); end
    do_store(32'd260, 32'h20, 4'b0001);
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL in_unf_clear got %h want 00000004", rd); end
  endtask

  task automatic test_input_full();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) push_in(32'hA0 + i);
    vectors++;
    if (bus_if.in_ready !== 1'b0) begin miscompares++; $display("FAIL infull_ready got %0b want 0", bus_if.in_ready); end
    push_in(32'hFF);
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0407) begin miscompares++; $display("FAIL infull_status got %h want 00000407", rd); end
    @(negedge clk);
    bus_if.Addr = 32'd272; bus_if.MemRead = 1'b1;
    #1;
    vectors++;
    if (bus_if.in_ready !== 1'b0 || bus_if.ReadData !== 32'hA0) begin
      miscompares++; $display("FAIL infull_pop got rdy=%0b d=%h want rdy=0 d=a0", bus_if.in_ready, bus_if.ReadData);
    end
    @(posedge clk);
    #1 bus_if.MemRead = 1'b0;
    for (int i = 1; i < 4; i++) begin
      do_load(32'd272, rd);
      vectors++;
      if (rd !== 32'hA0 + i) begin miscompares++; $display("FAIL infull_order got %h want %h", rd, 32'hA0 + i); end
    end
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL infull_empty got %h want 00000004", rd); end
  endtask

  task automatic test_enqueue_load_empty();
    logic [31:0] rd;
    @(negedge clk);
    bus_if.in_valid = 1'b1; bus_if.in_data = 32'h55; bus_if.Addr = 32'd272; bus_if.MemRead = 1'b1;
    #1;
    vectors++;
    if (bus_if.ReadData !== 32'h0) begin miscompares++; $display("FAIL simul_rd got %h want 0", bus_if.ReadData); end
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0; bus_if.MemRead = 1'b0;
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0125) begin miscompares++; $display("FAIL simul_status got %h want 00000125", rd); end
    do_load(32'd272, rd);
    vectors++;
    if (rd !== 32'h55) begin miscompares++; $display("FAIL simul_word got %h want 55", rd); end
    do_store(32'd260, 32'h30, 4'b0001);
  endtask

  task automatic test_ignored();
    logic [31:0] rd;
    do_store(32'd272, 32'h77, 4'b1111);
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL ign_store_in0 got %h want 00000004", rd); end
    @(negedge clk);
    bus_if.Addr = 32'd256; bus_if.MemRead = 1'b1;
    #1;
    vectors++;
    if (bus_if.Hit !== 1'b1 || bus_if.ReadData !== 32'h0) begin
      miscompares++; $display("FAIL ign_load_out0 got hit=%0b d=%h want hit=1 d=0", bus_if.Hit, bus_if.ReadData);
    end
    bus_if.Addr = 32'd512;
    #1;
    vectors++;
    if (bus_if.Hit !== 1'b0 || bus_if.ReadData !== 32'h0) begin
      miscompares++; $display("FAIL ign_nohit got hit=%0b d=%h want hit=0 d=0", bus_if.Hit, bus_if.ReadData);
    end
    @(posedge clk);
    #1 bus_if.MemRead = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    do_store(32'd256, 32'h1, 4'b1111);
    do_store(32'd256, 32'h2, 4'b1111);
    push_in(32'h3);
    @(negedge clk);
    rst = 1'b1; bus_if.out_ready = 1'b1; bus_if.in_valid = 1'b1; bus_if.in_data = 32'h99;
    @(posedge clk);
    #1 rst = 1'b0; bus_if.out_ready = 1'b0; bus_if.in_valid = 1'b0;
    vectors++;
    if (bus_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got %0b want 0", bus_if.out_valid); end
    do_load(32'd260, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL rstmid_status got %h want 00000004", rd); end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.Addr = '0; bus_if.WriteData = '0; bus_if.ByteEn = '0;
    bus_if.MemWrite = 1'b0; bus_if.MemRead = 1'b0;
    bus_if.out_ready = 1'b0; bus_if.in_data = '0; bus_if.in_valid = 1'b0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_overflow();
    test_full_push_pop();
    test_input();
    test_input_full();
    test_enqueue_load_empty();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
